// File: rtl/toy_imem_arbiter_if.sv
// Bundle of the fetch, debug, memory and perf signals around toy_imem_arbiter.
// slave: arbiter side; master: requesters/memory side.
interface toy_imem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  f_req_vld;
    logic                  f_req_rdy;
    logic [ADDR_WIDTH-1:0] f_req_addr;
    logic                  f_ack_vld;
    logic                  f_ack_rdy;
    logic [DATA_WIDTH-1:0] f_ack_data;
    logic                  f_flush;

    logic                  d_req_vld;
    logic                  d_req_rdy;
    logic [ADDR_WIDTH-1:0] d_req_addr;
    logic                  d_ack_vld;
    logic                  d_ack_rdy;
    logic [DATA_WIDTH-1:0] d_ack_data;

    logic                  mem_req_vld;
    logic                  mem_req_rdy;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_ack_vld;
    logic                  mem_ack_rdy;
    logic [DATA_WIDTH-1:0] mem_ack_data;

    logic [31:0]           perf_drop_cnt;
    logic [31:0]           perf_conflict_cnt;

    modport slave (
        input  f_req_vld, f_req_addr, f_ack_rdy, f_flush,
        input  d_req_vld, d_req_addr, d_ack_rdy,
        input  mem_req_rdy, mem_ack_vld, mem_ack_data,
        output f_req_rdy, f_ack_vld, f_ack_data,
        output d_req_rdy, d_ack_vld, d_ack_data,
        output mem_req_vld, mem_req_addr, mem_ack_rdy,
        output perf_drop_cnt, perf_conflict_cnt
    );

    modport master (
        output f_req_vld, f_req_addr, f_ack_rdy, f_flush,
        output d_req_vld, d_req_addr, d_ack_rdy,
        output mem_req_rdy, mem_ack_vld, mem_ack_data,
        input  f_req_rdy, f_ack_vld, f_ack_data,
        input  d_req_rdy, d_ack_vld, d_ack_data,
        input  mem_req_vld, mem_req_addr, mem_ack_rdy,
        input  perf_drop_cnt, perf_conflict_cnt
    );
endinterface

// File: rtl/toy_imem_arbiter.sv
// Round-robin fetch/debug arbiter for one in-order instruction-memory port, with a tag FIFO
// for response routing and fetch-flush dropping. Define TOY_IMEM_ARB_PERF_EN for perf counters.
module toy_imem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    toy_imem_arbiter_if.slave bus
);
    localparam int unsigned      PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] r_src;
    logic [MAX_OUTSTANDING-1:0] r_drop;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_last;

    logic                  w_busy;
    logic                  w_head_src;
    logic                  w_head_drop;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_credit;
    logic                  w_any_req;
    logic                  w_win_dbg;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_ack_data;
    logic                  w_mem_ack_rdy;
    logic                  w_f_ack_vld;
    logic                  w_d_ack_vld;
    logic [CNT_W-1:0]      w_cnt_nxt;

    assign w_busy      = (r_cnt != '0);
    assign w_head_src  = r_src[r_rptr];
    // Flush must discard a fetch head in the same cycle, before its drop bit is written.
    assign w_head_drop = r_drop[r_rptr] | (bus.f_flush & ~w_head_src);

    always_comb begin
        w_mem_ack_rdy = 1'b0;
        w_f_ack_vld   = 1'b0;
        w_d_ack_vld   = 1'b0;
        if (w_busy) begin
            if (w_head_drop) begin
                w_mem_ack_rdy = 1'b1;
            end else if (w_head_src) begin
                w_d_ack_vld   = bus.mem_ack_vld;
                w_mem_ack_rdy = bus.d_ack_rdy;
            end else begin
                w_f_ack_vld   = bus.mem_ack_vld;
                w_mem_ack_rdy = bus.f_ack_rdy;
            end
        end
    end

    assign w_ack_data      = bus.mem_ack_data;
    assign bus.mem_ack_rdy = w_mem_ack_rdy;
    assign bus.f_ack_vld   = w_f_ack_vld;
    assign bus.d_ack_vld   = w_d_ack_vld;
    assign bus.f_ack_data  = w_ack_data;
    assign bus.d_ack_data  = w_ack_data;

    assign w_pop     = w_busy & bus.mem_ack_vld & w_mem_ack_rdy;
    assign w_credit  = (r_cnt < CNT_MAX) | w_pop;
    assign w_any_req = bus.f_req_vld | bus.d_req_vld;
    // Debug wins when it is alone, or when both contend and fetch was granted last.
    assign w_win_dbg  = bus.d_req_vld & (~bus.f_req_vld | ~r_last);
    assign w_win_addr = w_win_dbg ? bus.d_req_addr : bus.f_req_addr;

    assign bus.mem_req_vld  = w_credit & w_any_req;
    assign bus.mem_req_addr = w_win_addr;
    assign bus.f_req_rdy    = w_credit & bus.mem_req_rdy & bus.f_req_vld & ~w_win_dbg;
    assign bus.d_req_rdy    = w_credit & bus.mem_req_rdy & w_win_dbg;

    assign w_push    = w_credit & w_any_req & bus.mem_req_rdy;
    assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_drop <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_last <= 1'b1;
        end else begin
            // Marking free slots too is harmless: a push always rewrites its slot's drop bit.
            if (bus.f_flush) begin
                r_drop <= r_drop | ~r_src;
            end
            if (w_push) begin
                r_src[r_wptr]  <= w_win_dbg;
                r_drop[r_wptr] <= 1'b0;
                r_wptr         <= r_wptr + PTR_W'(1);
                r_last         <= w_win_dbg;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef TOY_IMEM_ARB_PERF_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_pop & w_head_drop) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (bus.f_req_vld & bus.d_req_vld) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_drop_cnt     = r_drop_cnt;
    assign bus.perf_conflict_cnt = r_conflict_cnt;
`else
    assign bus.perf_drop_cnt     = '0;
    assign bus.perf_conflict_cnt = '0;
`endif

endmodule
